// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package fetch_pkg;

  // Canonical RV32I NOP (addi x0, x0, 0); what decode sees out of reset.
  localparam logic [31:0] RV_NOP  = 32'h0000_0013;
  localparam logic [31:0] PC_STEP = 32'd4;

  // FETCH: free to issue a request.
  // WAIT : one request outstanding, response wanted.
  // KILL : one request outstanding, response must be dropped (redirected away).
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    KILL  = 2'd2
  } fetch_state_e;

  // One fetched instruction as handed to decode.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_pkt_t;

  // Instruction addresses are always word aligned; low bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched instruction that decode cannot take yet.
// Latency: push is visible on buf_valid/buf_pkt the cycle after the push.
// Backpressure: none internally; the owner must not push while full (one request in flight guarantees it).
//
// Ports:
//   clk, rst_n         core clock, async active-low reset
//   push, push_pkt     write the slot (sets valid)
//   pop                release the slot
//   flush              synchronous clear, wins over push and pop
//   buf_valid, buf_pkt current slot contents
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output logic       buf_valid,
  output fetch_pkt_t buf_pkt
);

  logic       valid_q, valid_d;
  fetch_pkt_t pkt_q, pkt_d;

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (pop) begin
      valid_d = 1'b0;
    end
    if (push) begin
      valid_d = 1'b1;
      pkt_d   = push_pkt;
    end
    // A redirect invalidates whatever was parked here.
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_pkt   = pkt_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// IF stage: owns the PC, fetches one instruction at a time from imem, feeds the IF/ID register.
// Latency: request in cycle N, response >= N+1, IF/ID loaded at the end of the response cycle.
// Backpressure: stall_d holds IF/ID; one response parks in the skid buffer, which then blocks new requests.
//
// Ports:
//   clk, rst_n                      core clock, async active-low reset
//   imem_req_valid/ready, imem_addr fetch request handshake, address = pc_q
//   imem_rsp_valid, imem_rsp_data   instruction return (no backpressure from IF)
//   redirect_valid, redirect_pc     taken branch/jump from EX, highest priority
//   stall_d                         decode cannot accept this cycle
//   if_id_*                         IF/ID pipeline register contents
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [XLEN-1:0] if_id_instr
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         if_id_valid_q, if_id_valid_d;
  fetch_pkt_t   if_id_q, if_id_d;

  logic         buf_valid;
  fetch_pkt_t   buf_pkt;
  logic         buf_push, buf_pop;

  logic         req_fire;
  logic         rsp_accept;
  logic         if_id_free;
  fetch_pkt_t   rsp_pkt;

  // Requests are held off while a response is parked (so the buffer can never
  // overflow) and during a redirect (pc_q is about to be replaced). Gating with
  // rst_n keeps the request low for the whole reset window.
  assign imem_req_valid = rst_n && (state_q == FETCH) && !buf_valid && !redirect_valid;
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response that arrives together with a redirect is wrong-path and is dropped.
  assign rsp_accept = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
  assign if_id_free = !if_id_valid_q || !stall_d;

  assign rsp_pkt = '{pc:       req_pc_q,
                     pc_plus4: req_pc_q + PC_STEP,
                     instr:    imem_rsp_data};

  // The buffer has priority into IF/ID (it is older), so a fresh response can
  // only bypass it when the buffer is empty.
  assign buf_push = rsp_accept && !(if_id_free && !buf_valid);
  assign buf_pop  = buf_valid && if_id_free && !redirect_valid;

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_pkt  (rsp_pkt),
    .pop       (buf_pop),
    .flush     (redirect_valid),
    .buf_valid (buf_valid),
    .buf_pkt   (buf_pkt)
  );

  // PC, request tracking and fetch state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;

    if (req_fire) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + PC_STEP;   // wraps naturally at 2^32
    end

    case (state_q)
      FETCH: begin
        if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // With a redirect and no response yet, the in-flight fetch must still
        // be drained, but its data is now useless.
        if (imem_rsp_valid) begin
          state_d = FETCH;
        end else if (redirect_valid) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (imem_rsp_valid) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (redirect_valid) begin
      pc_d = word_align(redirect_pc);
    end
  end

  // IF/ID register.
  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_d       = if_id_q;

    if (redirect_valid) begin
      // Squash even under stall: the held instruction is on the wrong path.
      if_id_valid_d = 1'b0;
    end else if (if_id_free) begin
      if (buf_valid) begin
        if_id_valid_d = 1'b1;
        if_id_d       = buf_pkt;
      end else if (rsp_accept) begin
        if_id_valid_d = 1'b1;
        if_id_d       = rsp_pkt;
      end else begin
        // Bubble; payload fields keep their last value.
        if_id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_q       <= '{pc: 32'h0, pc_plus4: 32'h0, instr: RV_NOP};
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_q       <= if_id_d;
    end
  end

  assign if_id_valid    = if_id_valid_q;
  assign if_id_pc       = if_id_q.pc;
  assign if_id_pc_plus4 = if_id_q.pc_plus4;
  assign if_id_instr    = if_id_q.instr;

endmodule
